// File: rtl/ita_input_row_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ita_input_row_packer_pkg
// Description : Shared sizes and types for the ITA input-row packer.
// Revision    : 1.0 - initial release
// ============================================================================
package ita_input_row_packer_pkg;

  localparam int unsigned WI         = 8;
  localparam int unsigned E          = 64;
  localparam int unsigned S          = 64;
  localparam int unsigned BEAT_WIDTH = 64;

  localparam int unsigned BEATS_PER_ROW  = (E * WI) / BEAT_WIDTH;
  localparam int unsigned ELEMS_PER_BEAT = BEAT_WIDTH / WI;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned INPUT_ADDR_WIDTH = idx_width(S);
  // One spare bit so requests above S can arrive and be saturated.
  localparam int unsigned SEQ_LEN_WIDTH    = $clog2(S + 1) + 1;

  typedef logic [BEAT_WIDTH-1:0]                 beat_t;
  typedef logic [idx_width(BEATS_PER_ROW)-1:0]   beat_cnt_t;
  typedef logic [INPUT_ADDR_WIDTH-1:0]           input_addr_t;
  typedef logic [SEQ_LEN_WIDTH-1:0]              seq_length_t;
  typedef logic [E-1:0][WI-1:0]                  row_data_t;

  typedef struct packed {
    input_addr_t addr;
    row_data_t   data;
  } write_port_t;

endpackage
`default_nettype wire

// File: rtl/ita_input_row_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : ita_input_row_packer_if
// Description : Beat-stream input and row-write output handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
interface ita_input_row_packer_if;
  import ita_input_row_packer_pkg::*;

  logic        beat_valid;
  logic        beat_ready;
  beat_t       beat_data;
  logic        write_valid;
  logic        write_ready;
  write_port_t write;

  // slave: the packer itself; master: the surrounding streamer/buffer
  modport slave (
    input  beat_valid,
    input  beat_data,
    input  write_ready,
    output beat_ready,
    output write_valid,
    output write
  );

  modport master (
    output beat_valid,
    output beat_data,
    output write_ready,
    input  beat_ready,
    input  write_valid,
    input  write
  );

endinterface
`default_nettype wire

// File: rtl/ita_input_row_packer.sv
`default_nettype none
// ============================================================================
// Module      : ita_input_row_packer
// Description : Packs narrow beats into full rows and writes them out by row.
// Revision    : 1.0 - initial release
// ============================================================================
module ita_input_row_packer
  import ita_input_row_packer_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  seq_length_t                  seq_length_i,
  ita_input_row_packer_if.slave        bus,
  output logic                         busy_o,
  output logic                         done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } state_e;

  state_e      state_q,    state_d;
  beat_cnt_t   beat_cnt_q, beat_cnt_d;
  input_addr_t row_cnt_q,  row_cnt_d;
  seq_length_t len_q,      len_d;
  row_data_t   row_q,      row_d;
  logic        done_q,     done_d;

  seq_length_t len_sat;
  logic        last_row;

  always_comb begin
    len_sat  = (seq_length_i > seq_length_t'(S)) ? seq_length_t'(S) : seq_length_i;
    last_row = ((seq_length_t'(row_cnt_q) + seq_length_t'(1)) == len_q);
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    row_cnt_d  = row_cnt_q;
    len_d      = len_q;
    row_d      = row_q;
    done_d     = 1'b0;

    if (clear_i) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
      row_cnt_d  = '0;
      len_d      = '0;
      row_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            len_d = len_sat;
            if (len_sat == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = FILL;
            end
          end
        end

        FILL: begin
          if (bus.beat_valid) begin
            // Constant-slice decode keeps the beat placement free of variable indexing.
            for (int k = 0; k < int'(BEATS_PER_ROW); k++) begin
              if (beat_cnt_q == beat_cnt_t'(k)) begin
                row_d[k*ELEMS_PER_BEAT +: ELEMS_PER_BEAT] = bus.beat_data;
              end
            end
            if (beat_cnt_q == beat_cnt_t'(BEATS_PER_ROW - 1)) begin
              beat_cnt_d = '0;
              state_d    = EMIT;
            end else begin
              beat_cnt_d = beat_cnt_q + beat_cnt_t'(1);
            end
          end
        end

        EMIT: begin
          if (bus.write_ready) begin
            if (last_row) begin
              state_d   = IDLE;
              row_cnt_d = '0;
              done_d    = 1'b1;
            end else begin
              row_cnt_d = row_cnt_q + input_addr_t'(1);
              state_d   = FILL;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      row_cnt_q  <= '0;
      len_q      <= '0;
      row_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      row_cnt_q  <= row_cnt_d;
      len_q      <= len_d;
      row_q      <= row_d;
      done_q     <= done_d;
    end
  end

  // Every output comes straight from flops, so no input reaches an output combinationally.
  assign bus.beat_ready  = (state_q == FILL);
  assign bus.write_valid = (state_q == EMIT);
  assign bus.write.addr  = row_cnt_q;
  assign bus.write.data  = row_q;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;

endmodule
`default_nettype wire
